// File: rtl/column_multi_dst_l1_collect_pkg.sv
// ============================================================================
// Module : column_multi_dst_l1_collect_pkg
// Purpose: Shared definitions for the column-wise L1 write-back collector.
//          Holds the FIFO occupancy state encoding, the per-entry header
//          struct and the flattened-message bit-index helper.
// Config : DECODER_4BIT_EN (selects the 4-bit message build in the top)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package column_multi_dst_l1_collect_pkg;

  localparam int unsigned FIFO_STATE_W = 2;

  // Occupancy of the 2-entry collector FIFO.
  typedef enum logic [FIFO_STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  // Control part of a FIFO entry; the message payload is appended in the
  // top where its width is known.
  typedef struct packed {
    logic dst_sel;
    logic last;
  } entry_hdr_t;

  // Bit position of (stride, bit-plane, message) in the flattened word.
  function automatic int unsigned msg_bit_idx(
    input int unsigned stride,
    input int unsigned plane,
    input int unsigned msg,
    input int unsigned quan_size,
    input int unsigned unit_size
  );
    return (stride * quan_size + plane) * unit_size + msg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/column_multi_dst_l1_collect_addr_ctr.sv
// ============================================================================
// Module : col_dst_addr_ctr
// Purpose: Per-bank write address counter with layer-completion pulse.
//          Advances on every pop, clears on a popped last word and wraps
//          after ADDR_DEPTH-1. layer_done_o pulses the cycle after a last pop.
// Ports  : clk_i        - clock, rising edge
//          rstn_i       - synchronous active-low reset
//          pop_i        - word written to this bank this cycle
//          last_i       - popped word is the last of its layer
//          addr_o       - current write address
//          layer_done_o - one-cycle pulse after the last word is written
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module col_dst_addr_ctr
  import column_multi_dst_l1_collect_pkg::*;
#(
  parameter int ADDR_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  pop_i,
  input  logic                  last_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  layer_done_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(ADDR_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  done_q;

  always_comb begin
    addr_d = addr_q;
    if (pop_i) begin
      // A layer end restarts the bank at 0; otherwise wrap at the depth.
      if (last_i || (addr_q == ADDR_MAX)) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      done_q <= pop_i && last_i;
    end
  end

  assign addr_o       = addr_q;
  assign layer_done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/column_multi_dst_l1_collect.sv
// ============================================================================
// Module : column_multi_dst_l1_collect
// Purpose: Write-back collector on the output side of the column-wise L1
//          message route. Buffers routed stride-group words in a 2-entry
//          FIFO and steers each to destination bank dst0 or dst1, each with
//          its own valid/ready handshake, wrapping address and layer-done.
// Ports  : sys_clk, rstn                     - clock / sync active-low reset
//          in_valid_i, in_ready_o            - input handshake
//          in_dst_sel_i, in_last_i, in_msg_i - word destination, layer end,
//                                              payload
//          dstN_valid_o, dstN_ready_i        - bank N write handshake
//          dstN_addr_o, dstN_data_o          - bank N write address / data
//          dstN_layer_done_o                 - bank N layer completion pulse
// Config : DECODER_4BIT_EN defined -> QUAN_SIZE must be 4, otherwise 3.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module column_multi_dst_l1_collect
  import column_multi_dst_l1_collect_pkg::*;
#(
  parameter int QUAN_SIZE        = 3,
  parameter int STRIDE_UNIT_SIZE = 51,
  parameter int STRIDE_WIDTH     = 5,
  parameter int ADDR_DEPTH       = 16,
  parameter int ADDR_WIDTH       = $clog2(ADDR_DEPTH),
  parameter int MSG_WIDTH        = STRIDE_WIDTH * QUAN_SIZE * STRIDE_UNIT_SIZE
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_dst_sel_i,
  input  logic                  in_last_i,
  input  logic [MSG_WIDTH-1:0]  in_msg_i,
  output logic                  dst0_valid_o,
  input  logic                  dst0_ready_i,
  output logic [ADDR_WIDTH-1:0] dst0_addr_o,
  output logic [MSG_WIDTH-1:0]  dst0_data_o,
  output logic                  dst0_layer_done_o,
  output logic                  dst1_valid_o,
  input  logic                  dst1_ready_i,
  output logic [ADDR_WIDTH-1:0] dst1_addr_o,
  output logic [MSG_WIDTH-1:0]  dst1_data_o,
  output logic                  dst1_layer_done_o
);

`ifdef DECODER_4BIT_EN
  localparam int EXP_QUAN_SIZE = 4;
`else
  localparam int EXP_QUAN_SIZE = 3;
`endif

  // Elaboration-time configuration checks.
  generate
    if (QUAN_SIZE != EXP_QUAN_SIZE) begin : g_quan_size_bad
      $error("column_multi_dst_l1_collect: QUAN_SIZE does not match build");
    end
    if (MSG_WIDTH != int'(msg_bit_idx(STRIDE_WIDTH - 1, QUAN_SIZE - 1,
                                      STRIDE_UNIT_SIZE - 1, QUAN_SIZE,
                                      STRIDE_UNIT_SIZE)) + 1) begin : g_msg_width_bad
      $error("column_multi_dst_l1_collect: MSG_WIDTH inconsistent with layout");
    end
  endgenerate

  typedef struct packed {
    entry_hdr_t           hdr;
    logic [MSG_WIDTH-1:0] msg;
  } entry_t;

  fifo_state_e          state_q;
  entry_t               slot0_q;   // head of FIFO
  entry_t               slot1_q;   // second entry, valid only in ST_FULL
  logic [MSG_WIDTH-1:0] data0_q;   // last data shown on dst0
  logic [MSG_WIDTH-1:0] data1_q;   // last data shown on dst1

  entry_t in_entry;
  logic   push;
  logic   has_head;
  logic   pop0;
  logic   pop1;
  logic   pop;

  assign in_entry.hdr.dst_sel = in_dst_sel_i;
  assign in_entry.hdr.last    = in_last_i;
  assign in_entry.msg         = in_msg_i;

  // Ready depends only on registered state, never on the bank readies.
  assign in_ready_o = (state_q != ST_FULL);
  assign push       = in_valid_i && in_ready_o;

  // The head is offered only to the bank it targets (strict FIFO order).
  assign has_head     = (state_q != ST_EMPTY);
  assign dst0_valid_o = has_head && !slot0_q.hdr.dst_sel;
  assign dst1_valid_o = has_head &&  slot0_q.hdr.dst_sel;
  assign pop0         = dst0_valid_o && dst0_ready_i;
  assign pop1         = dst1_valid_o && dst1_ready_i;
  assign pop          = pop0 || pop1;

  // Data follows the head while it targets the bank, else holds.
  assign dst0_data_o = dst0_valid_o ? slot0_q.msg : data0_q;
  assign dst1_data_o = dst1_valid_o ? slot0_q.msg : data1_q;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      data0_q <= dst0_data_o;
      data1_q <= dst1_data_o;
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            slot0_q <= in_entry;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            slot0_q <= in_entry;
          end else if (push) begin
            slot1_q <= in_entry;
            state_q <= ST_FULL;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            slot0_q <= slot1_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  col_dst_addr_ctr #(
    .ADDR_DEPTH (ADDR_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_ctr0 (
    .clk_i        (sys_clk),
    .rstn_i       (rstn),
    .pop_i        (pop0),
    .last_i       (slot0_q.hdr.last),
    .addr_o       (dst0_addr_o),
    .layer_done_o (dst0_layer_done_o)
  );

  col_dst_addr_ctr #(
    .ADDR_DEPTH (ADDR_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_ctr1 (
    .clk_i        (sys_clk),
    .rstn_i       (rstn),
    .pop_i        (pop1),
    .last_i       (slot0_q.hdr.last),
    .addr_o       (dst1_addr_o),
    .layer_done_o (dst1_layer_done_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_column_multi_dst_l1_collect.sv
// ============================================================================
// Module : tb_column_multi_dst_l1_collect
// Purpose: Self-checking bench for column_multi_dst_l1_collect: a table of
//          per-cycle vectors plus directed sequences for wrap/last, reset
//          while full and single-bit payload transport.
// Config : DECODER_4BIT_EN selects the 4-bit message build.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_column_multi_dst_l1_collect;

`ifdef DECODER_4BIT_EN
  localparam int Q       = 4;
  localparam int BIT_IDX = 1019;  // (4*4+3)*51+50
`else
  localparam int Q       = 3;
  localparam int BIT_IDX = 764;   // (4*3+2)*51+50
`endif
  localparam int MW = 5 * Q * 51;
  localparam int AW = 4;

  logic          sys_clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic          in_sel;
  logic          in_last;
  logic [MW-1:0] in_msg;
  logic          v0, v1, r0, r1, dn0, dn1;
  logic [AW-1:0] a0, a1;
  logic [MW-1:0] d0, d1;

  int n_checks = 0;
  int n_fail   = 0;

  column_multi_dst_l1_collect #(
    .QUAN_SIZE (Q)
  ) dut (
    .sys_clk           (sys_clk),
    .rstn              (rstn),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_dst_sel_i      (in_sel),
    .in_last_i         (in_last),
    .in_msg_i          (in_msg),
    .dst0_valid_o      (v0),
    .dst0_ready_i      (r0),
    .dst0_addr_o       (a0),
    .dst0_data_o       (d0),
    .dst0_layer_done_o (dn0),
    .dst1_valid_o      (v1),
    .dst1_ready_i      (r1),
    .dst1_addr_o       (a1),
    .dst1_data_o       (d1),
    .dst1_layer_done_o (dn1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         chk;
    bit         rst;
    bit         v;
    bit         sel;
    bit         last;
    logic [7:0] pay;
    bit         r0;
    bit         r1;
    bit         e_rdy;
    bit         e_v0;
    bit         e_v1;
    logic [3:0] e_a0;
    logic [3:0] e_a1;
    logic [7:0] e_d0;
    logic [7:0] e_d1;
    bit         e_dn0;
    bit         e_dn1;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input bit chk, input bit rst, input bit v, input bit sel, input bit last,
    input logic [7:0] pay, input bit rr0, input bit rr1,
    input bit e_rdy, input bit e_v0, input bit e_v1,
    input logic [3:0] e_a0, input logic [3:0] e_a1,
    input logic [7:0] e_d0, input logic [7:0] e_d1,
    input bit e_dn0, input bit e_dn1
  );
    vec_t t;
    t.chk = chk; t.rst = rst; t.v = v; t.sel = sel; t.last = last;
    t.pay = pay; t.r0 = rr0; t.r1 = rr1;
    t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_v1 = e_v1;
    t.e_a0 = e_a0; t.e_a1 = e_a1; t.e_d0 = e_d0; t.e_d1 = e_d1;
    t.e_dn0 = e_dn0; t.e_dn1 = e_dn1;
    return t;
  endfunction

  function automatic logic [MW-1:0] ext(input logic [7:0] p);
    return {{(MW-8){1'b0}}, p};
  endfunction

  task automatic check(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_data(input string nm, input int idx,
                            input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got low %0h expected low %0h (%0d bits differ)",
               nm, idx, act[31:0], exp[31:0], $countones(act ^ exp));
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit sel, input bit last,
                       input logic [MW-1:0] msg, input bit rr0, input bit rr1);
    rstn     = !rst;
    in_valid = v;
    in_sel   = sel;
    in_last  = last;
    in_msg   = msg;
    r0       = rr0;
    r1       = rr1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    //               chk rst v sel lst pay   r0 r1  rdy v0 v1 a0 a1 d0     d1     dn0 dn1
    vecs[0]  = mk(0, 1, 0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    // stream three dst0 words, addresses 0,1,2
    vecs[1]  = mk(1, 0, 1, 0, 0, 8'h11, 1, 0,  1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    vecs[2]  = mk(1, 0, 1, 0, 0, 8'h12, 1, 0,  1, 1, 0, 0, 0, 8'h11, 8'h00, 0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 8'h13, 1, 0,  1, 1, 0, 1, 0, 8'h12, 8'h00, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 8'h00, 1, 0,  1, 1, 0, 2, 0, 8'h13, 8'h00, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 8'h00, 1, 0,  1, 0, 0, 3, 0, 8'h13, 8'h00, 0, 0);
    // interleave dst0, dst1, dst0
    vecs[6]  = mk(1, 0, 1, 0, 0, 8'h21, 1, 1,  1, 0, 0, 3, 0, 8'h13, 8'h00, 0, 0);
    vecs[7]  = mk(1, 0, 1, 1, 0, 8'h22, 1, 1,  1, 1, 0, 3, 0, 8'h21, 8'h00, 0, 0);
    vecs[8]  = mk(1, 0, 1, 0, 0, 8'h23, 1, 1,  1, 0, 1, 4, 0, 8'h21, 8'h22, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 8'h00, 1, 1,  1, 1, 0, 4, 1, 8'h23, 8'h22, 0, 0);
    // dst0 backpressure: fills, third word waits for the first pop
    vecs[10] = mk(1, 0, 1, 0, 0, 8'h31, 0, 1,  1, 0, 0, 5, 1, 8'h23, 8'h22, 0, 0);
    vecs[11] = mk(1, 0, 1, 0, 0, 8'h32, 0, 1,  1, 1, 0, 5, 1, 8'h31, 8'h22, 0, 0);
    vecs[12] = mk(1, 0, 1, 0, 0, 8'h33, 0, 1,  0, 1, 0, 5, 1, 8'h31, 8'h22, 0, 0);
    vecs[13] = mk(1, 0, 1, 0, 0, 8'h33, 1, 1,  0, 1, 0, 5, 1, 8'h31, 8'h22, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 0, 8'h33, 0, 1,  1, 1, 0, 6, 1, 8'h32, 8'h22, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 8'h00, 1, 1,  0, 1, 0, 6, 1, 8'h32, 8'h22, 0, 0);
    vecs[16] = mk(1, 0, 0, 0, 0, 8'h00, 1, 1,  1, 1, 0, 7, 1, 8'h33, 8'h22, 0, 0);
    // last word on dst0: address clears, done pulses once
    vecs[17] = mk(1, 0, 1, 0, 1, 8'h41, 1, 1,  1, 0, 0, 8, 1, 8'h33, 8'h22, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 0, 8'h00, 1, 1,  1, 1, 0, 8, 1, 8'h41, 8'h22, 0, 0);
    vecs[19] = mk(1, 0, 0, 0, 0, 8'h00, 1, 1,  1, 0, 0, 0, 1, 8'h41, 8'h22, 1, 0);
    vecs[20] = mk(1, 0, 0, 0, 0, 8'h00, 1, 1,  1, 0, 0, 0, 1, 8'h41, 8'h22, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge sys_clk);
      drive(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].last,
            ext(vecs[i].pay), vecs[i].r0, vecs[i].r1);
      #1;
      if (vecs[i].chk) begin
        check("in_ready", i, 64'(in_ready), 64'(vecs[i].e_rdy));
        check("dst0_valid", i, 64'(v0), 64'(vecs[i].e_v0));
        check("dst1_valid", i, 64'(v1), 64'(vecs[i].e_v1));
        check("dst0_addr", i, 64'(a0), 64'(vecs[i].e_a0));
        check("dst1_addr", i, 64'(a1), 64'(vecs[i].e_a1));
        check_data("dst0_data", i, d0, ext(vecs[i].e_d0));
        check_data("dst1_data", i, d1, ext(vecs[i].e_d1));
        check("dst0_done", i, 64'(dn0), 64'(vecs[i].e_dn0));
        check("dst1_done", i, 64'(dn1), 64'(vecs[i].e_dn1));
      end
    end

    // dst1: 21 words wrap through 0..15 then 0..4, word 21 is last at addr 5.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      @(negedge sys_clk);
      drive(1'b0, c <= 21, 1'b1, c == 21, ext(8'(c)), 1'b0, 1'b1);
      #1;
      if (c >= 1) begin
        check("wrap_v1", c, 64'(v1), 64'd1);
        check("wrap_v0", c, 64'(v0), 64'd0);
        check("wrap_a1", c, 64'(a1), 64'((c - 1) % 16));
        check_data("wrap_d1", c, d1, ext(8'(c - 1)));
        check("wrap_dn1", c, 64'(dn1), 64'd0);
      end
    end
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    #1;
    check("last_v1", 0, 64'(v1), 64'd0);
    check("last_a1", 0, 64'(a1), 64'd0);
    check("last_dn1", 0, 64'(dn1), 64'd1);
    @(negedge sys_clk);
    #1;
    check("last_dn1_clr", 0, 64'(dn1), 64'd0);

    // Reset while FULL with addr0 = 7 and a last word at the head.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge sys_clk);
      drive(1'b0, 1'b1, 1'b0, 1'b0, ext(8'h50 + 8'(k)), 1'b1, 1'b0);
    end
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    #1;
    check("pre_rst_a0", 0, 64'(a0), 64'd7);
    check("pre_rst_v0", 0, 64'(v0), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, ext(8'h61), 1'b0, 1'b0);
    @(negedge sys_clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, ext(8'h62), 1'b0, 1'b0);
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("full_rdy", 0, 64'(in_ready), 64'd0);
    check_data("full_d0", 0, d0, ext(8'h61));
    drive(1'b1, 1'b1, 1'b0, 1'b0, ext(8'h63), 1'b1, 1'b1);
    @(negedge sys_clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    #1;
    check("rst_rdy", 0, 64'(in_ready), 64'd1);
    check("rst_v0", 0, 64'(v0), 64'd0);
    check("rst_v1", 0, 64'(v1), 64'd0);
    check("rst_a0", 0, 64'(a0), 64'd0);
    check("rst_dn0", 0, 64'(dn0), 64'd0);
    check_data("rst_d0", 0, d0, '0);
    @(negedge sys_clk);
    #1;
    check("rst_dn0_after", 0, 64'(dn0), 64'd0);
    check("rst_v0_after", 0, 64'(v0), 64'd0);

    // Single-bit transport at the top stride/plane/message.
    begin
      logic [MW-1:0] bitw;
      bitw = '0;
      bitw[BIT_IDX] = 1'b1;
      @(negedge sys_clk);
      drive(1'b0, 1'b1, 1'b0, 1'b0, bitw, 1'b1, 1'b0);
      @(negedge sys_clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      check("bit_v0", 0, 64'(v0), 64'd1);
      check("bit_set", 0, 64'(d0[BIT_IDX]), 64'd1);
      check("bit_count", 0, 64'($countones(d0)), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/column_multi_dst_l1_collect.md
# column_multi_dst_l1_collect

Write-back collector on the output side of the column-wise L1 message route. Accepts circularly-shifted stride-group messages, buffers them in a 2-entry FIFO, and steers each word to one of two destination memory banks (dst0/dst1). This is the inverse of the two-source input multiplexing ahead of the barrel shifters. Each bank has its own valid/ready write handshake, its own wrapping address counter, and a layer-completion pulse.

## Interface
Parameters:
- QUAN_SIZE, 3: message quantisation bits; must be 4 when DECODER_4BIT_EN is defined.
- STRIDE_UNIT_SIZE, 51: messages per stride group (QSN length).
- STRIDE_WIDTH, 5: number of stride groups.
- ADDR_DEPTH, 16: words per destination bank per layer.
- ADDR_WIDTH, $clog2(ADDR_DEPTH): bank address width.
- MSG_WIDTH, STRIDE_WIDTH*QUAN_SIZE*STRIDE_UNIT_SIZE: flattened word width.

Ports:
- sys_clk  in  1  single clock, rising edge.
- rstn  in  1  synchronous, active-low reset.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  collector can accept a word.
- in_dst_sel_i  in  1  destination bank: 0 = dst0, 1 = dst1.
- in_last_i  in  1  last word of the layer for the selected bank.
- in_msg_i  in  MSG_WIDTH  routed messages. Bit [(s*QUAN_SIZE+b)*STRIDE_UNIT_SIZE + k] is stride s, bit-plane b, message k.
- dst0_valid_o / dst1_valid_o  out  1  write request to bank.
- dst0_ready_i / dst1_ready_i  in  1  bank accepts write.
- dst0_addr_o / dst1_addr_o  out  ADDR_WIDTH  write address.
- dst0_data_o / dst1_data_o  out  MSG_WIDTH  write data.
- dst0_layer_done_o / dst1_layer_done_o  out  1  one-cycle pulse after the last word of the layer is written.

## Operation
- FIFO is 2 entries. Each entry holds {dst_sel, last, msg}. Control is an FSM tracking occupancy: EMPTY, ONE, FULL.
- Push = in_valid_i && in_ready_o. in_ready_o = (state != FULL); it is registered-state-only, with no combinational path from dstN_ready_i.
- Head entry handling:
  - Head entry is presented only to its selected bank: dstN_valid_o = (state != EMPTY) && head.dst_sel == N. The other bank's valid is 0.
  - dstN_data_o = head.msg whenever the head is selected for bank N; otherwise it holds its last value.
  - Pop = dstN_valid_o && dstN_ready_i.
- Transitions:
  - EMPTY: push → ONE.
  - ONE: push with no pop → FULL; pop with no push → EMPTY; push with pop → ONE.
  - FULL: pop → ONE. Push is impossible in FULL.
- Ordering is strict FIFO. A word for dst1 behind a stalled dst0 word waits (head-of-line blocking is intended).
- Per-bank address counter addrN:
  - dstN_addr_o = addrN. It increments by 1 on each pop to bank N.
  - If the popped word has last=1, addrN goes to 0.
  - If addrN == ADDR_DEPTH-1 and last=0, addrN wraps to 0.
- dstN_layer_done_o is a registered pulse, asserted the cycle after a pop to bank N with last=1.

## Timing
- Latency: a word pushed at edge t is visible on dstN_valid_o/data/addr after edge t; earliest pop is at edge t+1.
- Throughput: 1 word/cycle sustained while the selected bank holds ready high.
- Reset (rstn=0 at an edge) clears all of the following, regardless of in-flight traffic:
  - state → EMPTY, so in_ready_o=1 and dstN_valid_o=0;
  - addrN = 0, dstN_layer_done_o = 0, dstN_data_o = 0;
  - any buffered entries are discarded.
- Inputs are ignored while rstn=0.
- While dstN_valid_o=1 and ready is low, data and address are held stable until the pop.

## Configuration
- DECODER_4BIT_EN defined: 4-bit messages (bit-planes 0..3); QUAN_SIZE must be 4. An elaboration-time check fails if QUAN_SIZE != 4.
- DECODER_4BIT_EN undefined: 3-bit messages; an elaboration-time check fails if QUAN_SIZE != 3.
- FIFO storage and data ports scale via MSG_WIDTH. There is no other behavioural difference.

## Structure
- Shared package: FIFO state encoding (EMPTY/ONE/FULL), the entry struct {dst_sel, last, msg}, and the MSG_WIDTH bit-index helper function (stride, plane, message → bit).
- One natural sub-module, col_dst_addr_ctr: the wrapping/last-clearing address counter plus the layer_done pulse register. It is instantiated twice, once per bank.

## Test plan
- Reset, then push 3 words to dst0 with dst0_ready_i=1 → dst0_addr_o reads 0,1,2 on consecutive cycles; dst1_valid_o stays 0.
- Hold dst0_ready_i=0 and push 3 words → in_ready_o drops after the 2nd push; the 3rd word is accepted only after the first pop; data order is preserved.
- Interleave dst0, dst1, dst0 words with both readies high → addresses are dst0:0, dst1:0, dst0:1; each valid asserts only for its own bank.
- Push 16 words to dst1 with last=0, then a 17th word → addresses 0..15, then 0 (wrap). A word with last=1 at address 5 → the next address is 0 and dst1_layer_done_o pulses one cycle after that pop.
- Assert rstn=0 while FIFO is FULL and addr0=7 → next cycle in_ready_o=1, valids=0, addr0=0, with no spurious layer_done.
- With DECODER_4BIT_EN and QUAN_SIZE=4, push a word with only plane 3 of stride 4 message 50 set → the same single bit (index 1019) appears on dst0_data_o.
